// File: rtl/thermal_mask_gen_if.sv
// Command and mask-beat handshake bundle for thermal_mask_gen.
// master drives commands and accepts beats; slave is the generator.
interface thermal_mask_gen_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 16
);
  localparam int unsigned OFS_WIDTH = $clog2(DATA_WIDTH);
  localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH + 1);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [OFS_WIDTH-1:0]  cmd_ofs;
  logic                  mask_valid;
  logic                  mask_ready;
  logic [DATA_WIDTH-1:0] mask_data;
  logic                  mask_last;
  logic [CNT_WIDTH-1:0]  mask_cnt;

  modport master (
    output cmd_valid, cmd_len, cmd_ofs, mask_ready,
    input  cmd_ready, mask_valid, mask_data, mask_last, mask_cnt
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_ofs, mask_ready,
    output cmd_ready, mask_valid, mask_data, mask_last, mask_cnt
  );
endinterface

// File: rtl/thermal_mask_gen.sv
// Streaming thermometer-mask generator: one command -> one or more mask beats with popcount.
// Define THERM_OFFSET_EN to honour cmd_ofs (leading invalid bits in the first beat).
module thermal_mask_gen #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  thermal_mask_gen_if.slave bus,
  output logic              busy
);
  localparam int unsigned OFS_WIDTH = $clog2(DATA_WIDTH);
  localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam int unsigned REM_WIDTH = LEN_WIDTH + 1;
  localparam logic [REM_WIDTH-1:0] BeatBits = REM_WIDTH'(DATA_WIDTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state_q, state_d;
  logic [REM_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  init_q;
  logic                  load;
  logic                  cmd_hs, beat_hs;
  logic [REM_WIDTH-1:0]  span;
  logic [CNT_WIDTH-1:0]  fill;

`ifdef THERM_OFFSET_EN
  logic [OFS_WIDTH-1:0]  start_q, start_d;
  logic [CNT_WIDTH-1:0]  lead;
  assign span = {1'b0, bus.cmd_len} + REM_WIDTH'(bus.cmd_ofs);
`else
  assign span = {1'b0, bus.cmd_len};
`endif

  // cmd_ready stays low until the first clock after reset release.
  assign bus.cmd_ready  = init_q & ((state_q == StIdle) | (last_q & bus.mask_ready));
  assign bus.mask_valid = (state_q == StRun);
  assign bus.mask_data  = data_q;
  assign bus.mask_last  = last_q;
  assign bus.mask_cnt   = cnt_q;
  assign busy           = (state_q == StRun);

  assign cmd_hs  = bus.cmd_valid & bus.cmd_ready;
  assign beat_hs = (state_q == StRun) & bus.mask_ready;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
`ifdef THERM_OFFSET_EN
    start_d = start_q;
`endif
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          load    = 1'b1;
          rem_d   = span;
`ifdef THERM_OFFSET_EN
          start_d = bus.cmd_ofs;
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        if (beat_hs) begin
          if (!last_q) begin
            load    = 1'b1;
            rem_d   = rem_q - BeatBits;
`ifdef THERM_OFFSET_EN
            start_d = '0;
`endif
          end else if (cmd_hs) begin
            // Back-to-back command: reload without a bubble.
            load    = 1'b1;
            rem_d   = span;
`ifdef THERM_OFFSET_EN
            start_d = bus.cmd_ofs;
`endif
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next beat derived from the next rem/start so outputs are registered.
  always_comb begin
    fill   = (rem_d >= BeatBits) ? CNT_WIDTH'(DATA_WIDTH) : CNT_WIDTH'(rem_d);
    data_d = '0;
    last_d = (rem_d <= BeatBits);
`ifdef THERM_OFFSET_EN
    lead = CNT_WIDTH'(start_d);
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      data_d[i] = (i < 32'(fill)) && (i >= 32'(lead));
    end
    cnt_d = (fill > lead) ? (fill - lead) : '0;
`else
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      data_d[i] = (i < 32'(fill));
    end
    cnt_d = fill;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
`ifdef THERM_OFFSET_EN
      start_q <= '0;
`endif
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
`ifdef THERM_OFFSET_EN
      start_q <= start_d;
`endif
      init_q  <= 1'b1;
      if (load) begin
        data_q <= data_d;
        last_q <= last_d;
        cnt_q  <= cnt_d;
      end
    end
  end
endmodule

// File: doc/thermal_mask_gen.md
# thermal_mask_gen

Streaming thermometer-mask generator for the LDPC derate-matching datapath. It accepts a command giving a bit length, and optionally a start offset, over a valid/ready handshake. It then emits one or more DATA_WIDTH-wide mask beats whose set bits mark exactly the valid bit positions of that burst, with a last flag and a per-beat popcount. Downstream lane-select and combine logic uses the masks to gate soft bits across multi-beat code blocks, where a single-beat combinational thermometer is not enough.

## Interface
- DATA_WIDTH, 64: mask beat width in bits; must be a power of two, ≥ 8.
- LEN_WIDTH, 16: width of the command length field.
- OFS_WIDTH, $clog2(DATA_WIDTH): width of the start-offset field (derived; do not override).
- CNT_WIDTH, $clog2(DATA_WIDTH+1): width of the per-beat popcount (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_len  in  LEN_WIDTH  number of valid bits in the burst; 0 is legal.
- cmd_ofs  in  OFS_WIDTH  leading invalid bits in the first beat (used only with THERM_OFFSET_EN).
- mask_valid  out  1  mask beat present.
- mask_ready  in  1  downstream accepts the beat when mask_valid & mask_ready.
- mask_data  out  DATA_WIDTH  bit i = 1 if position i of this beat is valid.
- mask_last  out  1  final beat of the burst.
- mask_cnt  out  CNT_WIDTH  popcount of mask_data.
- busy  out  1  burst in progress (state RUN).

## Operation
- Define the span S = ofs + len, computed in LEN_WIDTH+1 bits so it never overflows. The burst has B = max(1, ceil(S/DATA_WIDTH)) beats.
- In beat k, bit i = 1 iff ofs ≤ k·DATA_WIDTH + i < S.
- len = 0 produces exactly one beat: all-zero mask, mask_cnt = 0, mask_last = 1.
- Internal registers:
  - rem (LEN_WIDTH+1 bits) = S − k·DATA_WIDTH.
  - start (OFS_WIDTH bits) = ofs for k = 0, and 0 for k > 0.
- Beat value: mask_data = therm(min(rem, DATA_WIDTH)) & ~therm(start), where therm(n) sets bits [n-1:0]. mask_cnt = min(rem, DATA_WIDTH) − start, clamped at 0.
- mask_last = (rem ≤ DATA_WIDTH).
- On every beat handoff: rem −= DATA_WIDTH and start ← 0.
- FSM, two states:
  - IDLE: cmd_ready = 1. A command handshake loads rem/start and registers the first beat. Go to RUN.
  - RUN: mask_valid = 1.
    - Handoff of a non-last beat: stay in RUN and register the next beat.
    - Handoff of the last beat with no new command: go to IDLE.
- Back-to-back commands:
  - In RUN, cmd_ready = mask_last & mask_ready.
  - A command accepted in the same cycle as the last-beat handoff loads directly and stays in RUN, with no bubble.
- Outputs are registered. mask_data, mask_last and mask_cnt hold stable while mask_valid & !mask_ready.
- Async reset, including mid-burst: state ← IDLE and the in-flight burst is dropped. Reset values are:
  - mask_valid = 0, mask_data = 0, mask_last = 0, mask_cnt = 0, busy = 0.
  - cmd_ready = 0 while rst_n is low, then 1 from the first clock after release.

## Timing
- Latency: command handshake at edge N puts beat 0 on mask_valid after edge N, i.e. one cycle.
- Throughput: one beat per cycle under continuous mask_ready. A stream of commands runs at B beats per command with zero idle cycles.
- The min/therm/popcount logic is combinational from registers and must close at the datapath clock for DATA_WIDTH = 128.
- No combinational path from mask_ready to mask_data/mask_valid. cmd_ready depends combinationally on mask_ready (RUN only).

## Configuration
- THERM_OFFSET_EN defined:
  - cmd_ofs is honoured as described above.
  - An offset with len = 0 still yields a single all-zero beat.
- THERM_OFFSET_EN undefined:
  - cmd_ofs is ignored and ofs is forced to 0, so masks are pure thermometer codes starting at bit 0.
  - The start register and the ~therm(start) term are removed.

## Test plan
All scenarios use DATA_WIDTH = 64.
- len=0, ofs=0 → one beat: mask_data=0, cnt=0, last=1, one cycle after the handshake.
- len=64 → one beat: all-ones, cnt=64, last=1. len=65 → two beats: all-ones/cnt 64, then 0x1/cnt 1/last.
- len=131, ofs=0, mask_ready held high → beats of ones, ones, 0x7 (cnt 3, last) on consecutive cycles; busy falls the cycle after.
- THERM_OFFSET_EN, ofs=60, len=8 → beat 0 = 0xF000_0000_0000_0000 (cnt 4), beat 1 = 0xF (cnt 4, last). Without the macro, the same command gives 0xFF (one beat).
- mask_ready toggled 1/0 randomly during a len=200 burst → every beat held stable while stalled; 4 beats total; cnt sum = 200.
- Two commands back-to-back (len=70, then len=10), then rst_n pulsed low during beat 0 of a third (len=300) → no bubble between the first two bursts. After reset: all outputs 0, IDLE, and the next command starts cleanly from beat 0.
